// File: rtl/dbg_pkg.sv
// Shared constants for the board debug controller: mode encodings and
// breakpoint address formation.
package dbg_pkg;

  localparam int unsigned MODE_W   = 2;
  localparam int unsigned BP_IDX_W = 8;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BP_SHIFT = 2;

  localparam logic [MODE_W-1:0] MODE_RUN     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_STEP    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BREAK   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_MEMVIEW = 2'd3;

  // Word index to byte address.
  function automatic logic [ADDR_W-1:0] bp_addr(input logic [BP_IDX_W-1:0] idx);
    return ADDR_W'(idx) << BP_SHIFT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and a registered one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Any sample that agrees with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_MAX) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/dbg_ctrl.sv
// Board-side debug controller: turns raw switches and buttons into the CPU
// debug controls (mode, single step, breakpoint, memory view address).
module dbg_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned SCAN_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   sw_mode,
  input  logic                sw_auto,
  input  logic [BP_IDX_W-1:0] sw_data,
  input  logic                btn_step,
  input  logic                btn_next,
  input  logic                btn_load,
  input  logic [ADDR_W-1:0]   pc_addr,
  output logic                memread_en,
  output logic [7:0]          out_addr,
  output logic                one_step_en,
  output logic                one_step,
  output logic                break_en,
  output logic [ADDR_W-1:0]   breakpoint,
  output logic                hit_led
);

  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [1:0] HIT_HOLD = 2'd2;

  logic [MODE_W-1:0]   r_mode_s1, r_mode_s2, r_mode;
  logic                r_auto_s1, r_auto_s2;
  logic [BP_IDX_W-1:0] r_data_s1, r_data_s2;
  logic [BP_IDX_W-1:0] r_bp_idx;
  logic [7:0]          r_out_addr;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic                r_hit;
  logic [1:0]          r_hit_hold;
  logic                r_one_step;

  logic w_lvl_step, w_lvl_next, w_lvl_load;
  logic w_pls_step, w_pls_next, w_pls_load;
  logic w_p_step, w_p_next, w_p_load;
  logic w_step_fire, w_scan_en, w_scan_tc, w_memview, w_break;
  logic [ADDR_W-1:0] w_breakpoint;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(clk), .rst_n(rst_n), .i_raw(btn_step), .o_level(w_lvl_step), .o_pulse(w_pls_step));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .rst_n(rst_n), .i_raw(btn_next), .o_level(w_lvl_next), .o_pulse(w_pls_next));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk(clk), .rst_n(rst_n), .i_raw(btn_load), .o_level(w_lvl_load), .o_pulse(w_pls_load));

  // A pulse only counts while the debounced press is still being held.
  assign w_p_step = w_pls_step & w_lvl_step;
  assign w_p_next = w_pls_next & w_lvl_next;
  assign w_p_load = w_pls_load & w_lvl_load;

  assign w_memview    = (r_mode == MODE_MEMVIEW);
  assign w_break      = (r_mode == MODE_BREAK);
  assign w_breakpoint = bp_addr(r_bp_idx);
  assign w_step_fire  = w_p_step & ((r_mode == MODE_STEP) | (w_break & r_hit));
  assign w_scan_en    = w_memview & r_auto_s2;
  assign w_scan_tc    = w_scan_en & (r_scan_cnt == SCAN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_s1  <= MODE_RUN;
      r_mode_s2  <= MODE_RUN;
      r_mode     <= MODE_RUN;
      r_auto_s1  <= 1'b0;
      r_auto_s2  <= 1'b0;
      r_data_s1  <= '0;
      r_data_s2  <= '0;
      r_bp_idx   <= '0;
      r_out_addr <= '0;
      r_scan_cnt <= '0;
      r_hit      <= 1'b0;
      r_hit_hold <= '0;
      r_one_step <= 1'b0;
    end else begin
      r_mode_s1  <= sw_mode;
      r_mode_s2  <= r_mode_s1;
      r_mode     <= r_mode_s2;
      r_auto_s1  <= sw_auto;
      r_auto_s2  <= r_auto_s1;
      r_data_s1  <= sw_data;
      r_data_s2  <= r_data_s1;
      r_one_step <= w_step_fire;

      if (w_p_load) r_bp_idx <= r_data_s2;

      // After a resume the match is ignored briefly so the CPU can leave the breakpoint.
      if (!w_break) begin
        r_hit      <= 1'b0;
        r_hit_hold <= '0;
      end else if (w_step_fire) begin
        r_hit      <= 1'b0;
        r_hit_hold <= HIT_HOLD;
      end else if (r_hit_hold != 2'd0) begin
        r_hit_hold <= r_hit_hold - 2'd1;
      end else if (pc_addr == w_breakpoint) begin
        r_hit <= 1'b1;
      end

      if (!w_scan_en || w_scan_tc) r_scan_cnt <= '0;
      else                         r_scan_cnt <= r_scan_cnt + SCAN_W'(1);

      // Manual and timed steps that coincide advance by one word only.
      if (w_memview && (w_p_next || w_scan_tc)) r_out_addr <= r_out_addr + 8'd1;
    end
  end

  assign memread_en  = w_memview;
  assign break_en    = w_break;
  assign one_step_en = (r_mode == MODE_STEP) | (w_break & r_hit);
  assign one_step    = r_one_step;
  assign breakpoint  = w_breakpoint;
  assign hit_led     = r_hit;
  assign out_addr    = r_out_addr;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Bench for dbg_ctrl with short debounce/scan periods; expected values come
// from latency arithmetic and a small address/breakpoint model.
module tb_dbg_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SCAN = 8;
  localparam int SYNC      = 2;
  localparam int PULSE_LAT = SYNC + int'(DEB) + 1;
  localparam int STEP_LAT  = PULSE_LAT + 1;
  localparam int NEXT_LAT  = PULSE_LAT + 1;
  localparam int LOAD_LAT  = PULSE_LAT + 1;
  localparam int MODE_LAT  = SYNC + 1;

  logic        clk, rst_n;
  logic [1:0]  sw_mode;
  logic        sw_auto;
  logic [7:0]  sw_data;
  logic        btn_step, btn_next, btn_load;
  logic [31:0] pc_addr;
  logic        memread_en, one_step_en, one_step, break_en, hit_led;
  logic [7:0]  out_addr;
  logic [31:0] breakpoint;

  int n_vec = 0, n_err = 0, cyc = 0, step_cnt = 0, last_step_cyc = 0;
  logic [7:0]  m_addr;
  logic [31:0] m_bp;

  dbg_ctrl #(.DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .rst_n(rst_n), .sw_mode(sw_mode), .sw_auto(sw_auto), .sw_data(sw_data),
    .btn_step(btn_step), .btn_next(btn_next), .btn_load(btn_load), .pc_addr(pc_addr),
    .memread_en(memread_en), .out_addr(out_addr), .one_step_en(one_step_en),
    .one_step(one_step), .break_en(break_en), .breakpoint(breakpoint), .hit_led(hit_led));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] bp_of(input logic [7:0] idx);
    return 32'(idx) * 32'd4;
  endfunction

  // Timer steps land every SCAN edges counted from the first enabled edge.
  function automatic bit scan_inc(input int k, input int first, input int last);
    return (k >= first) && (k <= last) && (((k - first + 1) % int'(SCAN)) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (one_step === 1'b1) begin
      step_cnt++;
      last_step_cyc = cyc;
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    sw_mode = m;
    repeat (MODE_LAT) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_mode = 2'($urandom); sw_auto = 1'($urandom); sw_data = 8'($urandom);
    btn_step = 1'b1; btn_next = 1'b1; btn_load = 1'b1; pc_addr = $urandom;
    repeat (3) tick();
    n_vec++; if ({memread_en, one_step_en, one_step, break_en, hit_led} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 00000", {memread_en, one_step_en, one_step, break_en, hit_led}); end
    n_vec++; if (out_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h expected 00", out_addr); end
    n_vec++; if (breakpoint !== 32'h0) begin n_err++; $display("FAIL reset_bp: got %h expected 0", breakpoint); end
    sw_mode = 2'd0; sw_auto = 1'b0; sw_data = 8'h00;
    btn_step = 1'b0; btn_next = 1'b0; btn_load = 1'b0; pc_addr = 32'h100;
    rst_n = 1'b1; m_addr = 8'h00; m_bp = 32'h0;
    repeat (12) tick();
    n_vec++; if ({memread_en, one_step_en, one_step, break_en, hit_led, out_addr} !== 13'b0) begin
      n_err++; $display("FAIL post_reset_idle: got %b expected all zero", {memread_en, one_step_en, one_step, break_en, hit_led, out_addr}); end
  endtask

  task automatic test_bounce();
    int h, n, rise;
    set_mode(2'd1);
    n_vec++; if ({one_step_en, break_en, memread_en} !== 3'b100) begin
      n_err++; $display("FAIL step_mode_ctrl: got %b expected 100", {one_step_en, break_en, memread_en}); end
    step_cnt = 0;
    n = 2 * $urandom_range(3, 5);
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(1, int'(DEB) - 1);
      btn_step = ~btn_step;
      repeat (h) tick();
    end
    btn_step = 1'b1;
    rise = cyc;
    repeat (12) tick();
    btn_step = 1'b0;
    repeat (10) tick();
    n_vec++; if (step_cnt !== 1) begin n_err++; $display("FAIL bounce_count: got %0d pulses expected 1", step_cnt); end
    n_vec++; if (last_step_cyc !== rise + STEP_LAT) begin
      n_err++; $display("FAIL bounce_latency: got cycle %0d expected %0d", last_step_cyc, rise + STEP_LAT); end
  endtask

  task automatic test_breakpoint();
    set_mode(2'd0);
    for (int i = 0; i < 4; i++) begin
      automatic logic [7:0] idx = (i == 3) ? 8'h05 : 8'($urandom);
      sw_data = idx;
      btn_load = 1'b1;
      for (int t = 1; t <= LOAD_LAT; t++) begin
        tick();
        if (t == LOAD_LAT - 1) begin
          n_vec++; if (breakpoint !== m_bp) begin n_err++; $display("FAIL load_early: got %h expected %h", breakpoint, m_bp); end
        end
      end
      m_bp = bp_of(idx);
      n_vec++; if (breakpoint !== m_bp) begin n_err++; $display("FAIL load_value: got %h expected %h", breakpoint, m_bp); end
      btn_load = 1'b0;
      repeat (8) tick();
    end
    pc_addr = 32'h14;
    repeat (2) tick();
    n_vec++; if (hit_led !== 1'b0) begin n_err++; $display("FAIL hit_in_run: got %b expected 0", hit_led); end
    set_mode(2'd2);
    n_vec++; if ({break_en, hit_led, one_step_en} !== 3'b100) begin
      n_err++; $display("FAIL break_entry: got %b expected 100", {break_en, hit_led, one_step_en}); end
    tick();
    n_vec++; if ({hit_led, one_step_en} !== 2'b11) begin
      n_err++; $display("FAIL hit_set: got %b expected 11", {hit_led, one_step_en}); end
    step_cnt = 0;
    btn_step = 1'b1;
    for (int t = 1; t <= STEP_LAT + 3; t++) begin
      tick();
      if (t == STEP_LAT) begin
        n_vec++; if ({one_step, hit_led} !== 2'b10) begin
          n_err++; $display("FAIL resume_pulse: got %b expected 10", {one_step, hit_led}); end
      end else if (t > STEP_LAT && t < STEP_LAT + 3) begin
        n_vec++; if ({one_step, hit_led} !== 2'b00) begin
          n_err++; $display("FAIL resume_hold_%0d: got %b expected 00", t - STEP_LAT, {one_step, hit_led}); end
      end else if (t == STEP_LAT + 3) begin
        n_vec++; if (hit_led !== 1'b1) begin n_err++; $display("FAIL rehit: got %b expected 1", hit_led); end
      end
    end
    btn_step = 1'b0;
    repeat (10) tick();
    n_vec++; if (step_cnt !== 1) begin n_err++; $display("FAIL resume_count: got %0d expected 1", step_cnt); end
  endtask

  task automatic test_mode_gating();
    sw_mode = 2'd0;
    repeat (MODE_LAT) tick();
    n_vec++; if ({break_en, one_step_en, hit_led} !== 3'b001) begin
      n_err++; $display("FAIL break_to_run: got %b expected 001", {break_en, one_step_en, hit_led}); end
    tick();
    n_vec++; if (hit_led !== 1'b0) begin n_err++; $display("FAIL hit_clear_run: got %b expected 0", hit_led); end
    pc_addr = 32'h100;
    step_cnt = 0;
    btn_step = 1'b1;
    repeat (12) tick();
    btn_step = 1'b0;
    repeat (10) tick();
    n_vec++; if (step_cnt !== 0) begin n_err++; $display("FAIL run_step_dropped: got %0d pulses expected 0", step_cnt); end
  endtask

  task automatic test_pc_sweep();
    logic exp_hit = 1'b0;
    logic [31:0] v;
    set_mode(2'd2);
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      if (v == m_bp) v = v ^ 32'h1;
      pc_addr = ($urandom_range(0, 5) == 0) ? m_bp : v;
      tick();
      exp_hit = exp_hit | (pc_addr == m_bp);
      n_vec++; if ({hit_led, one_step_en} !== {exp_hit, exp_hit}) begin
        n_err++; $display("FAIL pc_sweep_%0d: pc %h got %b expected %b", i, pc_addr, {hit_led, one_step_en}, {exp_hit, exp_hit}); end
    end
    pc_addr = 32'h100;
    set_mode(2'd0);
  endtask

  task automatic test_autoscan();
    logic [7:0] prev;
    int chg = 0;
    set_mode(2'd3);
    n_vec++; if ({memread_en, break_en, one_step_en} !== 3'b100) begin
      n_err++; $display("FAIL memview_ctrl: got %b expected 100", {memread_en, break_en, one_step_en}); end
    prev = out_addr;
    sw_auto = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      if (k == 41) sw_auto = 1'b0;
      tick();
      if (scan_inc(k, SYNC + 1, 40 + SYNC)) m_addr++;
      if (out_addr !== prev) chg++;
      prev = out_addr;
      n_vec++; if (out_addr !== m_addr) begin n_err++; $display("FAIL scan_k%0d: got %h expected %h", k, out_addr, m_addr); end
    end
    n_vec++; if (chg !== 5) begin n_err++; $display("FAIL scan_count: got %0d steps expected 5", chg); end
    sw_auto = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 11) btn_next = 1'b1;
      if (k == 21) btn_next = 1'b0;
      if (k == 33) sw_auto = 1'b0;
      tick();
      if (scan_inc(k, SYNC + 1, 32 + SYNC) || (k == 11 + NEXT_LAT - 1)) m_addr++;
      n_vec++; if (out_addr !== m_addr) begin n_err++; $display("FAIL coincide_k%0d: got %h expected %h", k, out_addr, m_addr); end
    end
  endtask

  task automatic test_memview_wrap();
    int last = 5000;
    int k_end = 5000;
    sw_auto = 1'b1;
    for (int k = 1; k <= k_end; k++) begin
      tick();
      if (scan_inc(k, SYNC + 1, last + SYNC)) m_addr++;
      n_vec++; if (out_addr !== m_addr) begin n_err++; $display("FAIL fill_k%0d: got %h expected %h", k, out_addr, m_addr); end
      if (m_addr == 8'hFE && last == 5000) begin
        sw_auto = 1'b0;
        last = k;
        k_end = k + 6;
      end
    end
    for (int p = 0; p < 2; p++) begin
      btn_next = 1'b1;
      for (int t = 1; t <= 16; t++) begin
        if (t == 11) btn_next = 1'b0;
        tick();
        if (t == NEXT_LAT) m_addr++;
        n_vec++; if ({memread_en, out_addr} !== {1'b1, m_addr}) begin
          n_err++; $display("FAIL wrap_p%0d_t%0d: got %b/%h expected 1/%h", p, t, memread_en, out_addr, m_addr); end
      end
    end
    set_mode(2'd0);
    n_vec++; if ({memread_en, out_addr} !== 9'h000) begin
      n_err++; $display("FAIL addr_kept: got %b/%h expected 0/00", memread_en, out_addr); end
  endtask

  task automatic test_reset_mid();
    set_mode(2'd1);
    btn_step = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    btn_step = 1'b0;
    #1;
    n_vec++; if ({memread_en, one_step_en, one_step, break_en, hit_led, out_addr, breakpoint} !== 45'b0) begin
      n_err++; $display("FAIL reset_mid_deb: got %b expected all zero", {memread_en, one_step_en, one_step, break_en, hit_led}); end
    repeat (2) tick();
    rst_n = 1'b1; m_addr = 8'h00; m_bp = 32'h0;
    step_cnt = 0;
    repeat (20) tick();
    n_vec++; if (step_cnt !== 0) begin n_err++; $display("FAIL reset_no_pulse: got %0d expected 0", step_cnt); end
    n_vec++; if ({one_step_en, breakpoint} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL reset_recover: got %b/%h expected 1/0", one_step_en, breakpoint); end
    set_mode(2'd3);
    sw_auto = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (scan_inc(k, SYNC + 1, 1000)) m_addr++;
    end
    n_vec++; if (out_addr !== m_addr) begin n_err++; $display("FAIL midscan_addr: got %h expected %h", out_addr, m_addr); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({memread_en, out_addr} !== 9'h000) begin
      n_err++; $display("FAIL reset_mid_scan: got %b/%h expected 0/00", memread_en, out_addr); end
    m_addr = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (scan_inc(k, MODE_LAT + 1, 1000)) m_addr++;
      n_vec++; if ({memread_en, out_addr} !== {(k >= MODE_LAT), m_addr}) begin
        n_err++; $display("FAIL rescan_k%0d: got %b/%h expected %b/%h", k, memread_en, out_addr, (k >= MODE_LAT), m_addr); end
    end
    sw_auto = 1'b0;
    set_mode(2'd0);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_breakpoint();
    test_mode_gating();
    test_pc_sweep();
    test_autoscan();
    test_memview_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
